dmem_console_uart: RTL and testbench

- Memory-mapped console transmitter on the core's data-memory bus (dmem valid/ready protocol); it is the responder for the core's byte-write console accesses.
- Characters written to the console data address are buffered in a FIFO and serialised as 8N1 UART frames on `tx_o`.
- A status word at a second address lets software poll the FIFO and transmitter state.

---
 rtl/dmem_console_uart.sv | 225 ++++++++++++++++++++++
 tb/tb_dmem_console_uart.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_console_uart.sv
// Memory-mapped console UART transmitter: a byte FIFO on the dmem bus drains into an 8N1 serialiser.
// Optional TX-empty interrupt output and status bit 3 are enabled by defining CONSOLE_TX_IRQ_EN.
module dmem_console_uart #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] DATA_ADDR  = 32'h000fffff,
    parameter logic [ADDR_WIDTH-1:0] STAT_ADDR  = 32'h000ffff8,
    parameter int unsigned           CLK_DIV    = 868,
    parameter int unsigned           FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            we_i,
    output logic [31:0]           rdata_o,
`ifdef CONSOLE_TX_IRQ_EN
    output logic                  irq_o,
`endif
    output logic                  tx_o
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BAUD_W = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // FIFO storage and control
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             fifo_empty;
    logic             fifo_full;

    // Transmitter state
    state_t           state_q;
    state_t           state_d;
    logic [BAUD_W-1:0] baud_q;
    logic [BAUD_W-1:0] baud_d;
    logic [2:0]       idx_q;
    logic [2:0]       idx_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic             tx_d;
    logic             pop;

    // Bus decode
    logic             data_hit;
    logic             stat_hit;
    logic             is_read;
    logic             stall;
    logic             accept;
    logic             push;
    logic [31:0]      status_word;
    logic [31:0]      rdata_d;

    logic             unused_bits;
    assign unused_bits = ^{addr_i[1:0], wdata_i[23:0]};

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);

    assign data_hit = valid_i && (addr_i[ADDR_WIDTH-1:2] == DATA_ADDR[ADDR_WIDTH-1:2]);
    assign stat_hit = valid_i && (addr_i[ADDR_WIDTH-1:2] == STAT_ADDR[ADDR_WIDTH-1:2]);
    assign is_read  = (we_i == 4'b0000);

    // Full comes from the registered count, so a same-cycle pop cannot admit a push
    assign stall  = data_hit && we_i[3] && fifo_full;
    assign accept = (data_hit || stat_hit) && !ready_o && !stall;
    assign push   = accept && data_hit && we_i[3];

    always_comb begin
        status_word       = '0;
        status_word[0]    = fifo_empty;
        status_word[1]    = fifo_full;
        status_word[2]    = (state_q != S_IDLE);
`ifdef CONSOLE_TX_IRQ_EN
        status_word[3]    = irq_o;
`endif
        status_word[15:8] = 8'(count_q);
    end

    always_comb begin
        rdata_d = '0;
        if (accept && stat_hit && !data_hit && is_read) begin
            rdata_d = status_word;
        end
    end

    // Bus response stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_o <= 1'b0;
            rdata_o <= '0;
        end else begin
            ready_o <= accept;
            rdata_o <= rdata_d;
        end
    end

    // FIFO payload carries no reset; only pointers and count are control
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= wdata_i[31:24];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Serialiser next-state; tx_d is the value the output flop takes at this edge
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_o;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr_q];
                    state_d = S_START;
                    baud_d  = BAUD_MAX;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_q == '0) begin
                    state_d = S_DATA;
                    idx_d   = 3'd0;
                    baud_d  = BAUD_MAX;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_MAX;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shift_q[idx_d];
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (baud_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            tx_o    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            tx_o    <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

`ifdef CONSOLE_TX_IRQ_EN
    // Registered TX-empty level: rises one edge after the queue drains and the line idles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= fifo_empty && (state_q == S_IDLE);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_console_uart.sv
// Directed bench for dmem_console_uart at CLK_DIV = 4, FIFO_DEPTH = 8; covers CONSOLE_TX_IRQ_EN when defined.
module tb_dmem_console_uart;

    localparam int CLK_DIV = 4;
    localparam logic [31:0] DATA_A = 32'h000fffff;
    localparam logic [31:0] STAT_A = 32'h000ffff8;
`ifdef CONSOLE_TX_IRQ_EN
    localparam logic [31:0] IDLE_STAT = 32'h00000009;
`else
    localparam logic [31:0] IDLE_STAT = 32'h00000001;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [3:0]  we_i = '0;
    logic        ready_o;
    logic [31:0] rdata_o;
    logic        tx_o;
`ifdef CONSOLE_TX_IRQ_EN
    logic        irq_o;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [8:0] mon_q[$];
    int         mon_t[$];

    dmem_console_uart #(
        .ADDR_WIDTH(32),
        .DATA_ADDR (DATA_A),
        .STAT_ADDR (STAT_A),
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .addr_i (addr_i),
        .wdata_i(wdata_i),
        .we_i   (we_i),
        .rdata_o(rdata_o),
`ifdef CONSOLE_TX_IRQ_EN
        .irq_o  (irq_o),
`endif
        .tx_o   (tx_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                       input int max_cyc, output logic [31:0] rd, output logic got, output int acc);
        valid_i = 1'b1;
        addr_i  = a;
        wdata_i = d;
        we_i    = we;
        got     = 1'b0;
        rd      = '0;
        acc     = -1;
        for (int i = 0; i < max_cyc && !got; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                got = 1'b1;
                rd  = rdata_o;
                acc = cyc;
            end
        end
        valid_i = 1'b0;
        we_i    = '0;
    endtask

    // Line receiver: samples mid-bit, logs {stop, data} and the cycle the start bit appeared
    initial begin : monitor
        logic [8:0] fr;
        int t0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && tx_o == 1'b0) begin
                t0 = cyc;
                step(2);
                for (int k = 0; k < 9; k++) begin
                    step(CLK_DIV);
                    fr[k] = tx_o;
                end
                mon_q.push_back(fr);
                mon_t.push_back(t0);
            end
        end
    end

    initial begin : stim
        logic [31:0] rd;
        logic        got;
        int          ta, t9, tr, n, late;
        logic [9:0]  frame;

        // Reset state
        step(3);
        check("rst_ready", ready_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_tx", tx_o, 1);
`ifdef CONSOLE_TX_IRQ_EN
        check("rst_irq", irq_o, 0);
`endif
        rst_n = 1'b1;
        step(2);
`ifdef CONSOLE_TX_IRQ_EN
        check("irq_after_rst", irq_o, 1);
`endif

        // Single byte 0x41: latency, bit pattern, return to idle
        frame = {1'b1, 8'h41, 1'b0};
        bus(DATA_A, 32'h41000000, 4'b1000, 20, rd, got, ta);
        check("t1_accept", got, 1);
        check("t1_tx_before", tx_o, 1);
`ifdef CONSOLE_TX_IRQ_EN
        check("t1_irq_at_accept", irq_o, 1);
`endif
        step(1);
        check("t1_ready_pulse", ready_o, 0);
        check("t1_start_edge", tx_o, 0);
`ifdef CONSOLE_TX_IRQ_EN
        check("t1_irq_drop", irq_o, 0);
`endif
        step(2);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("t1_bit%0d", k), tx_o, frame[k]);
            if (k < 9) step(CLK_DIV);
        end
        step(2);
        check("t1_line_idle", tx_o, 1);
`ifdef CONSOLE_TX_IRQ_EN
        check("t1_irq_still_low", irq_o, 0);
`endif
        step(1);
`ifdef CONSOLE_TX_IRQ_EN
        check("t1_irq_return", irq_o, 1);
`endif
        bus(STAT_A, 32'h0, 4'b0000, 20, rd, got, n);
        check("t1_stat_idle", rd, IDLE_STAT);
        bus(DATA_A, 32'h0, 4'b0000, 20, rd, got, n);
        check("data_read_got", got, 1);
        check("data_read_zero", rd, 0);
        step(10);
        mon_q.delete();
        mon_t.delete();

        // Three bytes queued, then status: count 2, busy
        bus(DATA_A, 32'h61000000, 4'b1000, 20, rd, got, n);
        bus(DATA_A, 32'h62000000, 4'b1000, 20, rd, got, n);
        bus(DATA_A, 32'h63000000, 4'b1000, 20, rd, got, n);
        bus(STAT_A, 32'h0, 4'b0000, 20, rd, got, n);
        check("stat_busy_cnt2", rd, 32'h00000204);
        step(200);
        check("three_frames", mon_q.size(), 3);
        for (int i = 0; i < 3 && i < mon_q.size(); i++) begin
            check($sformatf("three_byte%0d", i), mon_q[i], {1'b1, 8'h61 + 8'(i)});
        end
        mon_q.delete();
        mon_t.delete();

        // Write without lane 3 enable, then an unmapped read
        bus(DATA_A, 32'h5A000000, 4'b0001, 20, rd, got, n);
        check("we0001_ready", got, 1);
        bus(STAT_A, 32'h0, 4'b0000, 20, rd, got, n);
        check("we0001_stat", rd, IDLE_STAT);
        step(20);
        check("we0001_tx", tx_o, 1);
        check("we0001_no_frame", mon_q.size(), 0);
        bus(32'h00001000, 32'h0, 4'b0000, 10, rd, got, n);
        check("miss_no_ready", got, 0);

        // Lead byte in flight plus nine queued: ninth stalls until the lead byte's slot frees
        bus(DATA_A, 32'h2A000000, 4'b1000, 20, rd, got, ta);
        t9 = -1;
        for (int i = 0; i < 9; i++) begin
            bus(DATA_A, {8'h30 + 8'(i), 24'h0}, 4'b1000, 100, rd, got, t9);
        end
        check("fill_last_accept", got, 1);
        check("fill_stall_cycles", t9 - ta, 43);
        n = 0;
        while (mon_q.size() < 10 && n < 600) begin
            step(1);
            n++;
        end
        check("fill_frames", mon_q.size(), 10);
        if (mon_t.size() > 0) check("fill_first_start", mon_t[0] - ta, 1);
        for (int i = 0; i < 10 && i < mon_q.size(); i++) begin
            check($sformatf("fill_byte%0d", i), mon_q[i], {1'b1, (i == 0) ? 8'h2A : 8'h30 + 8'(i - 1)});
            if (i > 0) check($sformatf("fill_gap%0d", i), mon_t[i] - mon_t[i-1], 10 * CLK_DIV + 1);
        end
        step(10);

        // Reset in the middle of data bit 3 of 0x55
        bus(DATA_A, 32'h55000000, 4'b1000, 20, rd, got, ta);
        step(18);
        check("rstmid_bit3", tx_o, 0);
        rst_n = 1'b0;
        #1;
        check("rstmid_tx_high", tx_o, 1);
        check("rstmid_ready", ready_o, 0);
        step(2);
        check("rstmid_tx_held", tx_o, 1);
        rst_n = 1'b1;
        tr = cyc;
        step(1);
`ifdef CONSOLE_TX_IRQ_EN
        check("rstmid_irq", irq_o, 1);
`endif
        bus(STAT_A, 32'h0, 4'b0000, 20, rd, got, n);
        check("rstmid_stat", rd, IDLE_STAT);
        step(80);
        check("rstmid_tx_idle", tx_o, 1);
        late = 0;
        foreach (mon_t[i]) if (mon_t[i] >= tr) late++;
        check("rstmid_no_residual", late, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
